// File: rtl/rgb2bayer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2bayer_pkg
//  Description : Shared constants, state and CFA-phase types, and the
//                Bayer component selector for the RGB-to-Bayer frame writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb2bayer_pkg;

    localparam int c_COLS   = 246;
    localparam int c_ROWS   = 296;
    localparam int c_TOTAL  = c_COLS * c_ROWS;
    localparam int c_ADDR_W = 20;
    localparam int c_PIX_W  = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Encoded as {row_odd, col_odd} so the phase falls straight out of the
    // low bits of the row and column counters.
    typedef enum logic [1:0] {
        PH_B      = 2'd0,
        PH_G_EVEN = 2'd1,
        PH_G_ODD  = 2'd2,
        PH_R      = 2'd3
    } cfa_phase_t;

    function automatic cfa_phase_t cfa_phase(input logic row_odd, input logic col_odd);
        return cfa_phase_t'({row_odd, col_odd});
    endfunction

    // Pixel word layout is {R, G, B}.
    function automatic logic [7:0] cfa_pick(input cfa_phase_t ph, input logic [c_PIX_W-1:0] pix);
        logic [7:0] v;
        case (ph)
            PH_B:    v = pix[7:0];
            PH_R:    v = pix[23:16];
            default: v = pix[15:8];
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb2bayer_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2bayer_writer_if
//  Description : Pixel-stream input handshake and single-port memory write
//                bus of the RGB-to-Bayer frame writer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rgb2bayer_writer_if;
    import rgb2bayer_pkg::*;

    logic                I_RGB_data_valid;
    logic [7:0]          I_RGB_data_R;
    logic [7:0]          I_RGB_data_G;
    logic [7:0]          I_RGB_data_B;
    logic                I_RGB_ready;
    logic                mem_stall;
    logic                cen;
    logic                wen;
    logic [c_ADDR_W-1:0] addr;
    logic [7:0]          data_out;

    // Writer side: consumes pixels, drives the memory port.
    modport slave (
        input  I_RGB_data_valid, I_RGB_data_R, I_RGB_data_G, I_RGB_data_B,
        output I_RGB_ready,
        input  mem_stall,
        output cen, wen, addr, data_out
    );

    // Environment side: pixel source and memory.
    modport master (
        output I_RGB_data_valid, I_RGB_data_R, I_RGB_data_G, I_RGB_data_B,
        input  I_RGB_ready,
        output mem_stall,
        input  cen, wen, addr, data_out
    );
endinterface
`default_nettype wire

// File: rtl/rgb2bayer_writer_pix_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pix_fifo
//  Description : Small synchronous FIFO for input pixels. DEPTH must be a
//                power of two (>= 2); pointers carry one extra wrap bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end
endmodule
`default_nettype wire

// File: rtl/rgb2bayer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2bayer_writer
//  Description : Accepts one RGB frame in raster order and writes the Bayer
//                (BGGR) mosaic sample of each pixel to consecutive memory
//                words, with back-pressure from the memory via a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb2bayer_writer
    import rgb2bayer_pkg::*;
#(
    parameter int COLS       = c_COLS,
    parameter int ROWS       = c_ROWS,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          frame_start,
    rgb2bayer_writer_if.slave  bus,
    output logic               busy,
    output logic               done
);
    localparam int c_FRAME_PIX = COLS * ROWS;
    localparam int c_RW        = $clog2(ROWS);
    localparam int c_CW        = $clog2(COLS);

    state_t              r_state;
    logic [c_ADDR_W-1:0] r_in_cnt;
    logic [c_ADDR_W-1:0] r_waddr;
    logic [c_RW-1:0]     r_row;
    logic [c_CW-1:0]     r_col;
    logic                r_cen;
    logic                r_wen;
    logic [c_ADDR_W-1:0] r_addr;
    logic [7:0]          r_data;
    logic                r_busy;
    logic                r_done;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_PIX_W-1:0]  w_fifo_data;
    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_start;
    logic                w_last_in;
    logic                w_col_end;
    logic                w_last_wr;
    cfa_phase_t          w_phase;

    assign w_ready   = (r_state == ST_RUN) && !w_fifo_full;
    assign w_push    = bus.I_RGB_data_valid && w_ready;
    assign w_pop     = ((r_state == ST_RUN) || (r_state == ST_FLUSH)) &&
                       !w_fifo_empty && !bus.mem_stall;
    assign w_start   = (r_state == ST_IDLE) && frame_start;
    assign w_last_in = w_push && (r_in_cnt == c_ADDR_W'(c_FRAME_PIX - 1));
    assign w_col_end = (r_col == c_CW'(COLS - 1));
    assign w_last_wr = w_pop && w_col_end && (r_row == c_RW'(ROWS - 1));
    assign w_phase   = cfa_phase(r_row[0], r_col[0]);

    pix_fifo #(
        .WIDTH (c_PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({bus.I_RGB_data_R, bus.I_RGB_data_G, bus.I_RGB_data_B}),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Frame sequencer: state, accepted-pixel count and registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_in_cnt <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state  <= ST_RUN;
                        r_in_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_push)    r_in_cnt <= r_in_cnt + c_ADDR_W'(1);
                    if (w_last_in) r_state  <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (w_last_wr) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write port: one registered access per popped pixel; the address is a
    // running counter so no row*COLS multiply is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row   <= '0;
            r_col   <= '0;
            r_waddr <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
        end else if (w_start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_waddr <= '0;
            r_addr  <= '0;
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
        end else if (w_pop) begin
            r_cen   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= r_waddr;
            r_data  <= cfa_pick(w_phase, w_fifo_data);
            r_waddr <= r_waddr + c_ADDR_W'(1);
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + c_RW'(1);
            end else begin
                r_col <= r_col + c_CW'(1);
            end
        end else begin
            r_cen <= 1'b1;
            r_wen <= 1'b1;
        end
    end

    assign bus.I_RGB_ready = w_ready;
    assign bus.cen         = r_cen;
    assign bus.wen         = r_wen;
    assign bus.addr        = r_addr;
    assign bus.data_out    = r_data;
    assign busy            = r_busy;
    assign done            = r_done;
endmodule
`default_nettype wire

// File: tb/tb_rgb2bayer_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rgb2bayer_writer
//  Description : Scoreboard bench: a small odd-sized instance under random
//                valid/stall traffic and a default-sized instance for a full
//                frame plus a mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2bayer_writer;
    import rgb2bayer_pkg::*;

    localparam int S_COLS  = 5;
    localparam int S_ROWS  = 3;
    localparam int S_TOTAL = S_COLS * S_ROWS;
    localparam int B_TOTAL = c_TOTAL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ns, rst_nb, fs_s, fs_b;
    logic busy_s, done_s, busy_b, done_b;
    bit   small_fin = 0;
    bit   big_fin   = 0;

    rgb2bayer_writer_if if_s ();
    rgb2bayer_writer_if if_b ();

    rgb2bayer_writer #(.COLS(S_COLS), .ROWS(S_ROWS), .FIFO_DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_ns), .frame_start(fs_s), .bus(if_s.slave),
        .busy(busy_s), .done(done_s)
    );

    rgb2bayer_writer u_big (
        .clk(clk), .rst_n(rst_nb), .frame_start(fs_b), .bus(if_b.slave),
        .busy(busy_b), .done(done_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bayer BGGR rule applied to raster index idx of a frame cols wide.
    function automatic int bayer(input int idx, input int cols, input int r, input int g, input int b);
        int row;
        int col;
        row = idx / cols;
        col = idx % cols;
        if (row % 2 == 0) return (col % 2 == 0) ? b : g;
        return (col % 2 == 0) ? g : r;
    endfunction

    // ---------------- small instance: scoreboard + monitor ----------------
    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];
    wr_t s_e;
    int  mem_s [S_TOTAL];
    int  ref_s [S_TOTAL];
    int  s_writes = 0;
    int  s_dones  = 0;

    always @(negedge clk) begin
        if (rst_ns) begin
            if (if_s.cen == 1'b0) begin
                s_writes++;
                check("s_wen_low", if_s.wen, 0);
                if (exp_q.size() == 0) begin
                    check("s_unexpected_write", 1, 0);
                end else begin
                    s_e = exp_q.pop_front();
                    check("s_addr", if_s.addr, s_e.addr);
                    check("s_data", if_s.data_out, s_e.data);
                end
                if (int'(if_s.addr) < S_TOTAL) mem_s[if_s.addr] = int'(if_s.data_out);
            end
            if (done_s) begin
                s_dones++;
                check("s_done_after_last_write", s_writes, S_TOTAL);
            end
        end
    end

    task automatic run_small(input int p_valid, input int p_stall, input bit solid,
                             input int stall_at, input int fs_at);
        int idx, cyc, stall_cyc, stall_acc, post;
        bit v, in_stall;
        int r, g, b;
        idx = 0; cyc = 0; stall_cyc = 0; stall_acc = 0; post = 0;
        exp_q.delete();
        s_writes = 0;
        s_dones  = 0;
        for (int i = 0; i < S_TOTAL; i++) begin mem_s[i] = -1; ref_s[i] = -2; end

        // A pixel offered in IDLE must not be taken; start the frame.
        @(negedge clk);
        if_s.I_RGB_data_valid = 1'b1;
        if_s.mem_stall = 1'b0;
        #1 check("s_ready_idle", if_s.I_RGB_ready, 0);
        fs_s = 1'b1;

        while (idx < S_TOTAL && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            fs_s = (fs_at >= 0 && idx == fs_at);
            in_stall = (stall_at >= 0 && idx >= stall_at && stall_cyc < 10);
            if (in_stall) stall_cyc++;
            if_s.mem_stall = in_stall ? 1'b1 : ($urandom_range(99) < p_stall);
            v = ($urandom_range(99) < p_valid) || in_stall;
            r = solid ? 'h10 : int'($urandom_range(255));
            g = solid ? 'h20 : int'($urandom_range(255));
            b = solid ? 'h30 : int'($urandom_range(255));
            if_s.I_RGB_data_valid = v;
            if_s.I_RGB_data_R = 8'(r);
            if_s.I_RGB_data_G = 8'(g);
            if_s.I_RGB_data_B = 8'(b);
            #1;
            if (cyc == 1) check("s_busy_start", busy_s, 1);
            if (in_stall && stall_cyc >= 2) check("s_cen_stalled", if_s.cen, 1);
            if (in_stall && stall_cyc == 10) check("s_ready_full", if_s.I_RGB_ready, 0);
            if (v && if_s.I_RGB_ready) begin
                if (in_stall) stall_acc++;
                ref_s[idx] = bayer(idx, S_COLS, r, g, b);
                exp_q.push_back('{idx, ref_s[idx]});
                idx++;
            end
        end
        fs_s = 1'b0;
        if (idx < S_TOTAL) check("s_frame_accept_timeout", idx, S_TOTAL);
        if (stall_at >= 0) check("s_stall_accepts_le4", (stall_acc <= 4), 1);

        // Drain; keep offering a pixel through FLUSH/DONE, which must be refused.
        if_s.mem_stall = 1'b0;
        if_s.I_RGB_data_valid = 1'b1;
        while ((s_dones == 0 || post < 4) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            #1 check("s_ready_after_frame", if_s.I_RGB_ready, 0);
            if (s_dones > 0) post++;
        end
        if_s.I_RGB_data_valid = 1'b0;
        check("s_done_count", s_dones, 1);
        check("s_queue_empty", exp_q.size(), 0);
        check("s_busy_end", busy_s, 0);
        for (int i = 0; i < S_TOTAL; i++) check("s_mosaic", mem_s[i], ref_s[i]);
    endtask

    initial begin : small_seq
        rst_ns = 1'b0;
        fs_s = 1'b0;
        if_s.I_RGB_data_valid = 1'b0;
        if_s.I_RGB_data_R = '0;
        if_s.I_RGB_data_G = '0;
        if_s.I_RGB_data_B = '0;
        if_s.mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("s_rst_cen", if_s.cen, 1);
        check("s_rst_wen", if_s.wen, 1);
        check("s_rst_data", if_s.data_out, 0);
        check("s_rst_ready", if_s.I_RGB_ready, 0);
        check("s_rst_busy", busy_s, 0);
        check("s_rst_done", done_s, 0);
        rst_ns = 1'b1;

        run_small(100, 0, 1'b1, -1, -1);
        check("s_solid_a0", mem_s[0], 'h30);
        check("s_solid_a1", mem_s[1], 'h20);
        check("s_solid_a5", mem_s[5], 'h20);
        check("s_solid_a6", mem_s[6], 'h10);
        run_small(70, 30, 1'b0, -1, -1);
        run_small(100, 0, 1'b0, 7, 6);
        run_small(50, 50, 1'b0, -1, -1);
        small_fin = 1;
    end

    // ---------------- big instance: default frame size ----------------
    int b_exp    = 0;
    int b_writes = 0;
    int b_dones  = 0;

    always @(negedge clk) begin
        if (rst_nb) begin
            if (if_b.cen == 1'b0) begin
                b_writes++;
                check("b_addr", if_b.addr, b_exp);
                check("b_data", if_b.data_out, bayer(b_exp, c_COLS, 'h10, 'h20, 'h30));
                b_exp++;
            end
            if (done_b) b_dones++;
        end
    end

    initial begin : big_seq
        int n;
        int snap;
        rst_nb = 1'b0;
        fs_b = 1'b0;
        if_b.I_RGB_data_valid = 1'b0;
        if_b.I_RGB_data_R = 8'h10;
        if_b.I_RGB_data_G = 8'h20;
        if_b.I_RGB_data_B = 8'h30;
        if_b.mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("b_rst_cen", if_b.cen, 1);
        check("b_rst_busy", busy_b, 0);
        rst_nb = 1'b1;

        // Abandon a frame by reset once address 100 is being written.
        @(negedge clk);
        fs_b = 1'b1;
        if_b.I_RGB_data_valid = 1'b1;
        @(negedge clk);
        fs_b = 1'b0;
        n = 0;
        while (!(if_b.cen == 1'b0 && if_b.addr == 20'd100) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b_reached_addr100", if_b.addr, 100);
        #2 rst_nb = 1'b0;
        #1;
        check("b_abort_cen", if_b.cen, 1);
        check("b_abort_ready", if_b.I_RGB_ready, 0);
        check("b_abort_busy", busy_b, 0);
        check("b_abort_data", if_b.data_out, 0);
        @(negedge clk);
        rst_nb = 1'b1;
        snap = b_writes;
        repeat (5) @(negedge clk);
        check("b_no_write_after_reset", b_writes, snap);

        // Full default-size frame, continuous valid, no stall.
        b_exp = 0;
        b_writes = 0;
        b_dones = 0;
        fs_b = 1'b1;
        @(negedge clk);
        fs_b = 1'b0;
        n = 0;
        while (b_dones == 0 && n < 80000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        if_b.I_RGB_data_valid = 1'b0;
        check("b_write_count", b_writes, B_TOTAL);
        check("b_done_count", b_dones, 1);
        check("b_busy_end", busy_b, 0);
        big_fin = 1;
    end

    initial begin : finisher
        wait (small_fin && big_fin);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #900000;
        errors++;
        $display("FAIL watchdog: sequences incomplete, small=%0d big=%0d required 1", small_fin, big_fin);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end
endmodule
`default_nettype wire

// File: doc/rgb2bayer_writer.md
RGB2BAYER_WRITER -- requirements
Module: rgb2bayer_writer

Interface
REQ-001 Parameter COLS, default 246, meaning pixels per line.
REQ-002 Parameter ROWS, default 296, meaning lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 4, meaning input buffer entries (power of two).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 frame_start  in  1  single-cycle pulse that arms a new frame.
REQ-007 I_RGB_data_valid  in  1  input pixel valid.
REQ-008 I_RGB_data_R / I_RGB_data_G / I_RGB_data_B  in  8 each  input pixel, raster order.
REQ-009 I_RGB_ready  out  1  high when the buffer can accept a pixel this cycle.
REQ-010 mem_stall  in  1  memory cannot accept an access this cycle.
REQ-011 cen  out  1  memory chip enable, active-low.
REQ-012 wen  out  1  memory write enable, active-low.
REQ-013 addr  out  20  memory word address.
REQ-014 data_out  out  8  Bayer sample written to addr.
REQ-015 busy  out  1  frame in progress.
REQ-016 done  out  1  single-cycle pulse after the last write of a frame.

Function
REQ-017 States: IDLE, RUN, FLUSH, DONE; a 2-bit state register.
REQ-018 IDLE -> RUN on frame_start; row, col and addr clear to 0; busy rises on the next edge.
REQ-019 Input handshake: a pixel transfers on an edge with I_RGB_data_valid=1 and I_RGB_ready=1.
REQ-020 I_RGB_ready = (state==RUN) and FIFO not full; a full FIFO with a simultaneous pop accepts no pixel that cycle.
REQ-021 Input pixels are counted; when ROWS*COLS pixels have been accepted, state goes RUN -> FLUSH and ready drops.
REQ-022 In RUN or FLUSH, when the FIFO is non-empty and mem_stall=0, one pixel is popped and written on that edge.
REQ-023 A write drives cen=0, wen=0, addr=row*COLS+col and data_out=the selected component, all registered, for one cycle.
REQ-024 Otherwise cen=1, wen=1, and addr/data_out hold their last values.
REQ-025 Component select: even row, even col -> B; even row, odd col -> G; odd row, even col -> G; odd row, odd col -> R.
REQ-026 addr increments by 1 per write with no multiplier; col wraps at COLS-1 to 0 and increments row.
REQ-027 Write latency: a pixel accepted into an empty FIFO with mem_stall=0 appears on the memory port 2 edges later.
REQ-028 mem_stall=1 holds the FIFO head, cen=1, and the counters; no sample is dropped or duplicated.
REQ-029 FLUSH -> DONE after the write at row ROWS-1, col COLS-1 (addr=ROWS*COLS-1); done pulses for 1 cycle in DONE.
REQ-030 DONE -> IDLE unconditionally next cycle; busy falls with the transition to IDLE.
REQ-031 frame_start outside IDLE is ignored; a pixel offered in IDLE/FLUSH/DONE is not accepted.
REQ-032 A simultaneous push and pop on a non-empty, non-full FIFO leaves occupancy unchanged.

Reset
REQ-033 rst_n low asynchronously forces IDLE, empties the FIFO and clears row, col and addr.
REQ-034 rst_n low forces cen=1, wen=1, data_out=0, I_RGB_ready=0, busy=0 and done=0.
REQ-035 Reset mid-frame abandons the frame with no further writes; a new frame_start is required.

Structure
REQ-036 Package rgb2bayer_pkg shall hold COLS/ROWS defaults, TOTAL=COLS*ROWS, the state enum, and the CFA phase enum (B, G_EVEN, G_ODD, R).
REQ-037 One sub-module pix_fifo (24-bit wide, FIFO_DEPTH deep, full/empty flags, synchronous push/pop) shall hold the input buffer.
REQ-038 The implementation shall be 120-400 lines of RTL.

Verification
REQ-039 Solid frame R=8'h10, G=8'h20, B=8'h30, COLS=4, ROWS=2 -> writes addr 0..7 with data 30,20,30,20,20,10,20,10, then one done pulse.
REQ-040 Continuous valid, no stall, default size -> 72816 writes, addr 0..72815 consecutive, done exactly once.
REQ-041 mem_stall held high for 10 cycles mid-line -> ready falls after 4 pixels; writes resume at the same addr with none lost.
REQ-042 rst_n pulsed low at addr=100 -> cen=1 immediately; after a new frame_start the first write is at addr 0.
REQ-043 frame_start asserted during RUN, plus a valid pixel offered in DONE -> no counter restart and no extra write.
REQ-044 Random valid/stall, COLS=5 (odd), ROWS=3 -> the memory model matches the reference Bayer mosaic exactly.
